// File: rtl/alu_seq_if.sv
// Instruction, ALU and result signals between fetch, sequencer and ALU.
// The sequencer takes the master modport and the environment takes the slave modport.
interface alu_seq_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [2:0]  alu_op;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [7:0]  alu_ans;
  logic        alu_zero;
  logic        res_valid;
  logic [7:0]  res_data;
  logic        res_zero;
  logic [1:0]  res_rd;

  modport master (
    input  instr_valid, instr, alu_ans, alu_zero,
    output instr_ready, alu_op, alu_a, alu_b, res_valid, res_data, res_zero, res_rd
  );

  modport slave (
    output instr_valid, instr, alu_ans, alu_zero,
    input  instr_ready, alu_op, alu_a, alu_b, res_valid, res_data, res_zero, res_rd
  );
endinterface

// File: rtl/alu_seq.sv
// Sequencer: ALU op retires 3 cycles after accept, LI retires 2; instr_ready only in IDLE, so one instruction in flight.
// The ALU_SEQ_RETIRE_CNT_EN macro enables the retire counter; without it, retire_cnt is tied to 0.
module alu_seq (
  input  logic        clk,
  input  logic        rst_n,
  alu_seq_if.master   bus,
  input  logic [1:0]  dbg_sel,
  output logic [7:0]  dbg_data,
  output logic [15:0] retire_cnt
);
  typedef enum logic [1:0] {IDLE, ISSUE, WB} state_t;

  typedef struct packed {
    logic [2:0] op;
    logic [1:0] rd;
    logic [1:0] rs;
    logic       imm_sel;
    logic [7:0] imm;
  } instr_t;

  localparam logic [2:0] OP_LI = 3'b101;

  state_t     state_q, state_d;
  instr_t     instr_q, instr_d;
  instr_t     in_w;
  logic [7:0] regs_q [4];
  logic       res_valid_q;
  logic [7:0] res_data_q;
  logic       res_zero_q;
  logic [1:0] res_rd_q;
  logic [7:0] wb_data;
  logic       wb_zero;

  assign in_w = bus.instr;

  always_comb begin
    state_d         = state_q;
    instr_d         = instr_q;
    bus.instr_ready = 1'b0;
    bus.alu_op      = 3'b000;
    bus.alu_a       = 8'h00;
    bus.alu_b       = 8'h00;
    case (state_q)
      IDLE: begin
        bus.instr_ready = rst_n;
        if (bus.instr_valid && rst_n) begin
          instr_d = in_w;
          state_d = (in_w.op == OP_LI) ? WB : ISSUE;
        end
      end
      ISSUE: begin
        bus.alu_op = instr_q.op;
        bus.alu_a  = regs_q[instr_q.rs];
        bus.alu_b  = instr_q.imm_sel ? instr_q.imm : regs_q[instr_q.imm[1:0]];
        state_d    = WB;
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // LI bypasses the ALU and derives its zero flag locally.
  assign wb_data = (instr_q.op == OP_LI) ? instr_q.imm : bus.alu_ans;
  assign wb_zero = (instr_q.op == OP_LI) ? (instr_q.imm == 8'h00) : bus.alu_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      instr_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= 8'h00;
      res_zero_q  <= 1'b0;
      res_rd_q    <= 2'd0;
      for (int i = 0; i < 4; i++) regs_q[i] <= 8'h00;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      res_valid_q <= (state_q == WB);
      if (state_q == WB) begin
        regs_q[instr_q.rd] <= wb_data;
        res_data_q         <= wb_data;
        res_zero_q         <= wb_zero;
        res_rd_q           <= instr_q.rd;
      end
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_zero  = res_zero_q;
  assign bus.res_rd    = res_rd_q;
  assign dbg_data      = regs_q[dbg_sel];

`ifdef ALU_SEQ_RETIRE_CNT_EN
  logic [15:0] retire_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               retire_cnt_q <= 16'h0000;
    else if (state_q == WB)   retire_cnt_q <= retire_cnt_q + 16'd1;
  end

  assign retire_cnt = retire_cnt_q;
`else
  assign retire_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: registered ALU model plus directed instruction vectors and handshake/reset sequences.
module tb_alu_seq;
  logic        clk;
  logic        rst_n;
  logic [1:0]  dbg_sel;
  logic [7:0]  dbg_data;
  logic [15:0] retire_cnt;
  int          n_checks;
  int          n_fail;
  int          n_ret;

  alu_seq_if bus ();

  alu_seq u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .dbg_sel    (dbg_sel),
    .dbg_data   (dbg_data),
    .retire_cnt (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return a ^ b;
      3'b110:  return (a < b) ? 8'h01 : 8'h00;
      3'b111:  return (a == 8'h00) ? 8'h01 : 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  // Registered ALU: result and zero flag appear one cycle after the operands.
  always @(posedge clk) begin
    bus.alu_ans  <= alu_f(bus.alu_op, bus.alu_a, bus.alu_b);
    bus.alu_zero <= (alu_f(bus.alu_op, bus.alu_a, bus.alu_b) == 8'h00);
  end

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n)             n_ret = 0;
    else if (bus.res_valid) n_ret = n_ret + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input int n);
`ifdef ALU_SEQ_RETIRE_CNT_EN
    return 32'(n);
`else
    return 32'd0 & 32'(n);
`endif
  endfunction

  typedef struct {
    logic [15:0] instr;
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  data;
    logic        zero;
    logic [1:0]  rd;
    int          lat;
  } vec_t;

  vec_t vecs [10];
  int   lat;
  int   acc;
  int   pulses;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    //           instr     op    a      b      data   zero  rd    lat
    vecs[0] = '{16'hA905, 3'd0, 8'h00, 8'h00, 8'h05, 1'b0, 2'd1, 2}; // LI R1=05
    vecs[1] = '{16'h13FE, 3'd0, 8'h05, 8'hFE, 8'h03, 1'b0, 2'd2, 3}; // ADD R2=R1+FE wraps
    vecs[2] = '{16'h3A01, 3'd1, 8'h05, 8'h05, 8'h00, 1'b1, 2'd3, 3}; // SUB R3=R1-R1
    vecs[3] = '{16'hE600, 3'd7, 8'h00, 8'h00, 8'h01, 1'b0, 2'd0, 3}; // BZ R0=(R3==0)
    vecs[4] = '{16'hDD80, 3'd6, 8'h03, 8'h80, 8'h01, 1'b0, 2'd3, 3}; // SLT R3=R2<80
    vecs[5] = '{16'h95FF, 3'd4, 8'h03, 8'hFF, 8'hFC, 1'b0, 2'd2, 3}; // XOR R2=R2^FF
    vecs[6] = '{16'h4C01, 3'd2, 8'hFC, 8'h05, 8'h04, 1'b0, 2'd1, 3}; // AND R1=R2&R1
    vecs[7] = '{16'h6003, 3'd3, 8'h01, 8'h01, 8'h01, 1'b0, 2'd0, 3}; // OR R0=R0|R3
    vecs[8] = '{16'hB900, 3'd0, 8'h00, 8'h00, 8'h00, 1'b1, 2'd3, 2}; // LI R3=00
    vecs[9] = '{16'h3701, 3'd1, 8'h00, 8'h01, 8'hFF, 1'b0, 2'd2, 3}; // SUB R2=R3-1 wraps

    rst_n           = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr       = 16'h0000;
    dbg_sel         = 2'd0;
    #1;
    check("ready_in_reset", 32'(bus.instr_ready), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_ready", 32'(bus.instr_ready), 32'd1);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_res_data", 32'(bus.res_data), 32'd0);
    check("rst_res_zero", 32'(bus.res_zero), 32'd0);
    check("rst_res_rd", 32'(bus.res_rd), 32'd0);
    check("rst_alu_op", 32'(bus.alu_op), 32'd0);
    check("rst_alu_a", 32'(bus.alu_a), 32'd0);
    check("rst_alu_b", 32'(bus.alu_b), 32'd0);
    check("rst_retire_cnt", 32'(retire_cnt), 32'd0);

    for (int i = 0; i < 10; i++) begin
      bus.instr_valid = 1'b1;
      bus.instr       = vecs[i].instr;
      @(negedge clk);
      bus.instr_valid = 1'b0;
      bus.instr       = 16'h0000;
      check($sformatf("res_valid_width[%0d]", i), 32'(bus.res_valid), 32'd0);
      check($sformatf("ready_busy[%0d]", i), 32'(bus.instr_ready), 32'd0);
      check($sformatf("alu_op[%0d]", i), 32'(bus.alu_op), 32'(vecs[i].op));
      check($sformatf("alu_a[%0d]", i), 32'(bus.alu_a), 32'(vecs[i].a));
      check($sformatf("alu_b[%0d]", i), 32'(bus.alu_b), 32'(vecs[i].b));
      lat = 1;
      while (!bus.res_valid && lat < 10) begin
        @(negedge clk);
        lat++;
      end
      check($sformatf("latency[%0d]", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("res_data[%0d]", i), 32'(bus.res_data), 32'(vecs[i].data));
      check($sformatf("res_zero[%0d]", i), 32'(bus.res_zero), 32'(vecs[i].zero));
      check($sformatf("res_rd[%0d]", i), 32'(bus.res_rd), 32'(vecs[i].rd));
      check($sformatf("ready_with_res[%0d]", i), 32'(bus.instr_ready), 32'd1);
      dbg_sel = vecs[i].rd;
      #1;
      check($sformatf("dbg_data[%0d]", i), 32'(dbg_data), 32'(vecs[i].data));
    end
    @(negedge clk);
    #1;
    check("res_valid_last_width", 32'(bus.res_valid), 32'd0);
    check("retire_cnt_10", 32'(retire_cnt), exp_cnt(10));

    // Valid held high for 6 cycles; instr changes while not ready must be ignored.
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      bus.instr_valid = 1'b1;
      bus.instr       = (c == 1 || c == 2) ? 16'hB9AA : 16'h0B01;
      check($sformatf("hold_ready[%0d]", c), 32'(bus.instr_ready), (c % 3 == 0) ? 32'd1 : 32'd0);
      if (bus.instr_ready) acc++;
      @(negedge clk);
    end
    bus.instr_valid = 1'b0;
    bus.instr       = 16'h0000;
    check("hold_accepts", 32'(acc), 32'd2);
    check("hold_second_res", 32'(bus.res_valid), 32'd1);
    check("hold_second_data", 32'(bus.res_data), 32'h06);
    @(negedge clk);
    dbg_sel = 2'd1;
    #1;
    check("hold_r1", 32'(dbg_data), 32'h06);
    dbg_sel = 2'd3;
    #1;
    check("hold_r3_untouched", 32'(dbg_data), 32'h00);
    check("tb_retires", 32'(n_ret), 32'd12);
    check("retire_cnt_12", 32'(retire_cnt), exp_cnt(12));

    // Reset pulsed while an ADD is in ISSUE.
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr       = 16'h13FE;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    bus.instr       = 16'h0000;
    check("issue_alu_a", 32'(bus.alu_a), 32'h06);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", 32'(bus.instr_ready), 32'd0);
    check("midrst_alu_a", 32'(bus.alu_a), 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    repeat (5) begin
      if (bus.res_valid) pulses++;
      @(negedge clk);
    end
    check("midrst_no_res", 32'(pulses), 32'd0);
    for (int r = 0; r < 4; r++) begin
      dbg_sel = 2'(r);
      #1;
      check($sformatf("midrst_r%0d", r), 32'(dbg_data), 32'd0);
    end
    check("midrst_ready_after", 32'(bus.instr_ready), 32'd1);
    check("midrst_retire_cnt", 32'(retire_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, limit reached");
    $fatal(1);
  end
endmodule
